// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential signed/unsigned shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} seq_mul_state_t;

    // Counter must index bits 0..n-1 of the multiplier.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_sign_prep.sv
// Converts operands to unsigned magnitudes plus a result sign for the shift-add core.
module mul_sign_prep
    import seq_mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         signed_mul,
    output logic [n-1:0] mag_a,
    output logic [n-1:0] mag_b,
    output logic         neg
);

    // The magnitude of -2^(n-1) wraps to 2^(n-1), which is still correct as an unsigned value.
    always_comb begin
        mag_a = (signed_mul && a[n-1]) ? -a : a;
        mag_b = (signed_mul && b[n-1]) ? -b : b;
        neg   = signed_mul & (a[n-1] ^ b[n-1]);
    end

endmodule

// File: rtl/seq_signed_or_unsigned_mul.sv
// Multi-cycle shift-add multiplier with per-operation signed/unsigned selection.
// Optional macro SEQ_MUL_EARLY_TERM_EN ends iteration once the remaining multiplier bits are zero.
module seq_signed_or_unsigned_mul
    import seq_mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arg_vld,
    output logic           arg_rdy,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           signed_mul,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [2*n-1:0] res
);

    localparam int CW = cnt_width(n);

    seq_mul_state_t state;
    logic [CW-1:0]  cnt;
    logic [2*n-1:0] mcand;
    logic [n-1:0]   mplier;
    logic [2*n-1:0] acc;
    logic           neg_q;

    logic [n-1:0]   mag_a;
    logic [n-1:0]   mag_b;
    logic           neg;
    logic [2*n-1:0] sum;
    logic           last;

    mul_sign_prep #(.n(n)) u_sign_prep (
        .a          (a),
        .b          (b),
        .signed_mul (signed_mul),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .neg        (neg)
    );

    // Multiplier shifts right and multiplicand shifts left, so bit 0 always selects the partial product.
    always_comb begin
        sum = acc + (mplier[0] ? mcand : '0);
`ifdef SEQ_MUL_EARLY_TERM_EN
        last = (cnt == CW'(n - 1)) || (mplier[n-1:1] == '0);
`else
        last = (cnt == CW'(n - 1));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            arg_rdy <= 1'b1;
            res_vld <= 1'b0;
            res     <= '0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arg_vld) begin
                        mcand   <= {{n{1'b0}}, mag_a};
                        mplier  <= mag_b;
                        neg_q   <= neg;
                        acc     <= '0;
                        cnt     <= '0;
                        arg_rdy <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        res     <= neg_q ? -sum : sum;
                        res_vld <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        arg_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
